uart_rx_framed: RTL and testbench
=================================

// Module: uart_rx_framed
// PURPOSE
//  Parametrised UART receiver for the debug unit, next generation of the basic byte receiver.
//  Adds configurable data width, oversampling, parity, stop bits, input synchronisation and
//  start-glitch rejection. Adds parity/framing/break/overrun detection and a valid/ready output
//  register. Sits between the baud-rate tick generator and the debug command FSM / RX FIFO.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9, LSB first on the line
//  OVERSAMPLE  16  s_tick pulses per bit period, even, >= 4
//  PARITY_MODE 0   0 = none, 1 = even, 2 = odd
//  STOP_BITS   1   number of stop bits checked, 1 or 2
// PORTS
//  clk         in   1          system clock
//  rst         in   1          asynchronous reset, active low
//  rx          in   1          serial line, asynchronous, idles high
//  s_tick      in   1          oversample strobe, one clk wide, OVERSAMPLE per bit
//  dout        out  DATA_BITS  received word; valid while dout_valid
//  dout_valid  out  1          word held in output register
//  dout_ready  in   1          consumer accepts word when dout_valid & dout_ready
//  parity_err  out  1          parity mismatch for held word; qualified by dout_valid
//  frame_err   out  1          a stop bit sampled 0 for held word; qualified by dout_valid
//  break_det   out  1          held word is a line break; qualified by dout_valid
//  overrun     out  1          one-clk pulse: a completed frame was dropped (register full)
// BEHAVIOUR
//  - One clock. Reset is asynchronous, active low. Clock port is clk; reset port is rst.
//  - Reset values: all outputs 0, FSM IDLE, counters 0. Synchroniser flops reset to 1, so no
//    false start is seen after reset. Reset mid-frame discards the partial frame.
//  - rx passes a 2-FF synchroniser; all FSM decisions use the synchronised value rxs.
//  - s counter width $clog2(OVERSAMPLE); it advances only on s_tick. n counter width
//    $clog2(DATA_BITS)+1.
//  - IDLE: rxs==0 -> START, s=0.
//  - START: on tick at s==OVERSAMPLE/2-1: if rxs==0 -> DATA (s=0, n=0); else -> IDLE
//    (glitch rejected, nothing reported). Otherwise s++.
//  - DATA: on tick at s==OVERSAMPLE-1: s=0, shift b={rxs,b[DATA_BITS-1:1]}.
//    When n==DATA_BITS-1 -> PARITY if PARITY_MODE!=0, else STOP. Otherwise n++.
//  - PARITY: sample at s==OVERSAMPLE-1. perr = (^b ^ rxs) ^ (PARITY_MODE==2). -> STOP, n=0.
//  - STOP: sample at s==OVERSAMPLE-1; a 0 sample sets ferr. After STOP_BITS samples the frame
//    completes. Next state is IDLE, or BRK_WAIT if a break was detected.
//  - Break: b==0 AND parity bit (if any) ==0 AND a stop sample ==0. Sets break_det and
//    frame_err. BRK_WAIT holds until rxs==1, then -> IDLE; no new start is accepted meanwhile.
//  - Completion loads dout/parity_err/frame_err/break_det and sets dout_valid in the clk after
//    the final stop-bit sample tick. Error flags are per-word and replaced on every load.
//  - Handshake: dout_valid & dout_ready clears dout_valid next clk. If completion coincides
//    with acceptance, the new word loads and dout_valid stays 1; no overrun.
//  - Completion while dout_valid=1 and no acceptance: new frame dropped, old word kept,
//    overrun pulses 1 clk.
//  - s_tick while in IDLE/BRK_WAIT is ignored. Ticks only count in START/DATA/PARITY/STOP.
// STRUCTURE
//  - Package uart_pkg: FSM state encodings (IDLE, START, DATA, PARITY, STOP, BRK_WAIT) and
//    PARITY_NONE/EVEN/ODD constants. These are shared with the matching transmitter.
//  - Sub-module sync_2ff (width 1, reset value parameter = 1) for rx; reusable elsewhere.
//  - FSM+datapath is a registered state block plus one combinational next-state block.
// TESTING  (clk 10 ns, s_tick every 4 clk, OVERSAMPLE=16 unless noted)
//  1 8N1, send 0xA5 with dout_ready=1 -> one dout_valid pulse, dout=0xA5, all err=0.
//  2 PARITY_MODE=1, send 0x07 with parity bit 0 -> dout=0x07, parity_err=1. Repeat with
//    parity bit 1 -> parity_err=0.
//  3 rx low for 5 ticks then high -> FSM returns IDLE, no dout_valid. Then 0x3C -> received.
//  4 STOP_BITS=2, 0x55 with second stop bit 0 -> frame_err=1, break_det=0, dout=0x55.
//  5 rx held low 3 frame times -> one word, dout=0, break_det=1, frame_err=1. No further
//    words until rx high and a new start bit arrives.
//  6 dout_ready=0, send 0x11 then 0x22 -> dout stays 0x11, overrun pulses once.
//    Assert rst mid third frame -> all outputs 0; the next full frame is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants,
// common to the receiver and the matching transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; reset value is a parameter so
// idle-high lines can come out of reset without a spurious edge.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with parity, framing, break and overrun detection,
// presenting each word through a valid/ready output register.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = PARITY_NONE,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 s_tick,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int S_W = $clog2(OVERSAMPLE);
    localparam int N_W = $clog2(DATA_BITS) + 1;

    localparam logic [S_W-1:0] S_ONE  = S_W'(1);
    localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [N_W-1:0] N_ONE       = N_W'(1);
    localparam logic [N_W-1:0] N_LAST_DATA = N_W'(DATA_BITS - 1);
    localparam logic [N_W-1:0] N_LAST_STOP = N_W'(STOP_BITS - 1);
    localparam logic           ODD_BIT     = (PARITY_MODE == PARITY_ODD);
    localparam bit             HAS_PARITY  = (PARITY_MODE != PARITY_NONE);

    logic rxs;

    uart_state_e          state_reg, state_next;
    logic [S_W-1:0]       s_reg, s_next;
    logic [N_W-1:0]       n_reg, n_next;
    logic [DATA_BITS-1:0] b_reg, b_next;
    logic                 perr_reg, perr_next;
    logic                 ferr_reg, ferr_next;
    logic                 pzero_reg, pzero_next;
    logic [DATA_BITS-1:0] dout_reg, dout_next;
    logic                 dout_valid_reg, dout_valid_next;
    logic                 parity_err_reg, parity_err_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 break_det_reg, break_det_next;
    logic                 overrun_reg, overrun_next;

    logic done;
    logic stop_ferr;
    logic frame_brk;
    logic accept;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            s_reg          <= '0;
            n_reg          <= '0;
            b_reg          <= '0;
            perr_reg       <= 1'b0;
            ferr_reg       <= 1'b0;
            pzero_reg      <= 1'b0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            break_det_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            s_reg          <= s_next;
            n_reg          <= n_next;
            b_reg          <= b_next;
            perr_reg       <= perr_next;
            ferr_reg       <= ferr_next;
            pzero_reg      <= pzero_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
            break_det_reg  <= break_det_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        s_next          = s_reg;
        n_next          = n_reg;
        b_next          = b_reg;
        perr_next       = perr_reg;
        ferr_next       = ferr_reg;
        pzero_next      = pzero_reg;
        dout_next       = dout_reg;
        dout_valid_next = dout_valid_reg;
        parity_err_next = parity_err_reg;
        frame_err_next  = frame_err_reg;
        break_det_next  = break_det_reg;
        overrun_next    = 1'b0;
        done            = 1'b0;
        stop_ferr       = ferr_reg;
        frame_brk       = 1'b0;
        accept          = dout_valid_reg & dout_ready;

        case (state_reg)
            ST_IDLE: begin
                if (!rxs) begin
                    state_next = ST_START;
                    s_next     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_reg == S_HALF) begin
                        if (!rxs) begin
                            state_next = ST_DATA;
                            s_next     = '0;
                            n_next     = '0;
                            perr_next  = 1'b0;
                            ferr_next  = 1'b0;
                            // With no parity bit the break test must not depend on it
                            pzero_next = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        s_next = s_reg + S_ONE;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_reg == S_LAST) begin
                        s_next = '0;
                        b_next = {rxs, b_reg[DATA_BITS-1:1]};
                        if (n_reg == N_LAST_DATA) begin
                            n_next     = '0;
                            state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            n_next = n_reg + N_ONE;
                        end
                    end else begin
                        s_next = s_reg + S_ONE;
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        perr_next  = (^b_reg) ^ rxs ^ ODD_BIT;
                        pzero_next = ~rxs;
                        state_next = ST_STOP;
                    end else begin
                        s_next = s_reg + S_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_reg == S_LAST) begin
                        s_next    = '0;
                        stop_ferr = ferr_reg | ~rxs;
                        ferr_next = stop_ferr;
                        if (n_reg == N_LAST_STOP) begin
                            done       = 1'b1;
                            frame_brk  = (b_reg == '0) && pzero_reg && stop_ferr;
                            state_next = frame_brk ? ST_BRK_WAIT : ST_IDLE;
                        end else begin
                            n_next = n_reg + N_ONE;
                        end
                    end else begin
                        s_next = s_reg + S_ONE;
                    end
                end
            end
            ST_BRK_WAIT: begin
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A completion on the same clk as an acceptance refills the register
        if (accept) begin
            dout_valid_next = 1'b0;
        end
        if (done) begin
            if (!dout_valid_reg || accept) begin
                dout_next       = b_reg;
                dout_valid_next = 1'b1;
                parity_err_next = perr_reg;
                frame_err_next  = stop_ferr;
                break_det_next  = frame_brk;
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign break_det  = break_det_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: three instances (8N1, 8E1, 8N2) driven
// one at a time; accepted words are captured and compared against expectations.
module tb_uart_rx_framed;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } word_t;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    logic [1:0] tick_cnt = 2'd0;

    logic       rx_l    [3];
    logic       ready   [3];
    logic [7:0] dout_w  [3];
    logic       valid_w [3];
    logic       pe_w    [3];
    logic       fe_w    [3];
    logic       bk_w    [3];
    logic       ov_w    [3];

    word_t exp_q[$];
    word_t got_q[$];
    int    ovr_cnt [3] = '{0, 0, 0};
    int    pass_cnt = 0;
    int    total_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_cnt <= tick_cnt + 2'd1;
        s_tick   <= (tick_cnt == 2'd3);
    end

    uart_rx_framed #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_8n1 (
        .clk(clk), .rst(rst_n), .rx(rx_l[0]), .s_tick(s_tick),
        .dout(dout_w[0]), .dout_valid(valid_w[0]), .dout_ready(ready[0]),
        .parity_err(pe_w[0]), .frame_err(fe_w[0]), .break_det(bk_w[0]), .overrun(ov_w[0])
    );

    uart_rx_framed #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_8e1 (
        .clk(clk), .rst(rst_n), .rx(rx_l[1]), .s_tick(s_tick),
        .dout(dout_w[1]), .dout_valid(valid_w[1]), .dout_ready(ready[1]),
        .parity_err(pe_w[1]), .frame_err(fe_w[1]), .break_det(bk_w[1]), .overrun(ov_w[1])
    );

    uart_rx_framed #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) u_dut_8n2 (
        .clk(clk), .rst(rst_n), .rx(rx_l[2]), .s_tick(s_tick),
        .dout(dout_w[2]), .dout_valid(valid_w[2]), .dout_ready(ready[2]),
        .parity_err(pe_w[2]), .frame_err(fe_w[2]), .break_det(bk_w[2]), .overrun(ov_w[2])
    );

    // Inputs change at posedge+1, so values seen here are those at the next edge
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid_w[i] && ready[i]) begin
                got_q.push_back(word_t'{dout_w[i], pe_w[i], fe_w[i], bk_w[i]});
            end
            if (ov_w[i]) begin
                ovr_cnt[i]++;
            end
        end
    end

    task automatic drive(input int idx, input logic v, input int nclk);
        rx_l[idx] = v;
        repeat (nclk) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int idx, input logic [7:0] data, input bit has_par,
                              input logic par_bit, input int nstop, input logic last_stop,
                              input int last_len);
        drive(idx, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive(idx, data[i], BIT_CLKS);
        if (has_par) drive(idx, par_bit, BIT_CLKS);
        for (int k = 0; k < nstop; k++) begin
            if (k == nstop - 1) drive(idx, last_stop, last_len);
            else                drive(idx, 1'b1, BIT_CLKS);
        end
        drive(idx, 1'b1, BIT_CLKS);
    endtask

    task automatic get_word(output word_t g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int c = 0; c < 2000; c++) begin
            if (got_q.size() > 0) begin
                g  = got_q.pop_front();
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({dout_w[i], valid_w[i], pe_w[i], fe_w[i], bk_w[i], ov_w[i]} !== 13'd0)
                $display("FAIL reset inst%0d: outputs=%h required 0", i,
                         {dout_w[i], valid_w[i], pe_w[i], fe_w[i], bk_w[i], ov_w[i]});
            else pass_cnt++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_8n1();
        word_t e, g;
        bit ok;
        int ov0 = ovr_cnt[0];
        exp_q.push_back(word_t'{8'hA5, 1'b0, 1'b0, 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, BIT_CLKS);
        get_word(g, ok);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || g !== e) $display("FAIL basic_a5: got=%h ok=%0d required=%h", g, ok, e);
        else begin pass_cnt++; $display("word basic 8n1 got=%h", g); end
        total_cnt++;
        if (got_q.size() != 0 || ovr_cnt[0] != ov0)
            $display("FAIL basic_single: extra=%0d overruns=%0d required 0/0",
                     got_q.size(), ovr_cnt[0] - ov0);
        else pass_cnt++;
    endtask

    task automatic test_parity();
        word_t e, g;
        bit ok;
        logic pbit;
        for (int r = 0; r < 2; r++) begin
            pbit = (r == 1);
            exp_q.push_back(word_t'{8'h07, (r == 0), 1'b0, 1'b0});
            send_frame(1, 8'h07, 1'b1, pbit, 1, 1'b1, BIT_CLKS);
            get_word(g, ok);
            e = exp_q.pop_front();
            total_cnt++;
            if (!ok || g !== e) $display("FAIL parity_pbit%0d: got=%h ok=%0d required=%h", pbit, g, ok, e);
            else begin pass_cnt++; $display("word parity pbit=%0d got=%h", pbit, g); end
        end
    endtask

    task automatic test_glitch();
        word_t e, g;
        bit ok;
        drive(0, 1'b0, 5 * 4);
        drive(0, 1'b1, 200);
        total_cnt++;
        if (got_q.size() != 0) $display("FAIL glitch_reject: words=%0d required 0", got_q.size());
        else pass_cnt++;
        exp_q.push_back(word_t'{8'h3C, 1'b0, 1'b0, 1'b0});
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1, BIT_CLKS);
        get_word(g, ok);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || g !== e) $display("FAIL glitch_next: got=%h ok=%0d required=%h", g, ok, e);
        else begin pass_cnt++; $display("word after glitch got=%h", g); end
    endtask

    task automatic test_two_stop();
        word_t e, g;
        bit ok;
        exp_q.push_back(word_t'{8'h55, 1'b0, 1'b1, 1'b0});
        // Shortened low second stop bit so the line is high again before a false start is qualified
        send_frame(2, 8'h55, 1'b0, 1'b0, 2, 1'b0, 48);
        drive(2, 1'b1, 200);
        get_word(g, ok);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || g !== e) $display("FAIL two_stop: got=%h ok=%0d required=%h", g, ok, e);
        else begin pass_cnt++; $display("word 2-stop got=%h", g); end
        total_cnt++;
        if (got_q.size() != 0) $display("FAIL two_stop_extra: words=%0d required 0", got_q.size());
        else pass_cnt++;
    endtask

    task automatic test_break();
        word_t e, g;
        bit ok;
        exp_q.push_back(word_t'{8'h00, 1'b0, 1'b1, 1'b1});
        drive(0, 1'b0, 3 * 10 * BIT_CLKS);
        get_word(g, ok);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || g !== e) $display("FAIL break_word: got=%h ok=%0d required=%h", g, ok, e);
        else begin pass_cnt++; $display("word break got=%h", g); end
        drive(0, 1'b0, 2 * BIT_CLKS);
        drive(0, 1'b1, 4 * BIT_CLKS);
        total_cnt++;
        if (got_q.size() != 0) $display("FAIL break_hold: words=%0d required 0", got_q.size());
        else pass_cnt++;
        exp_q.push_back(word_t'{8'hC3, 1'b0, 1'b0, 1'b0});
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1, 1'b1, BIT_CLKS);
        get_word(g, ok);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || g !== e) $display("FAIL break_recover: got=%h ok=%0d required=%h", g, ok, e);
        else begin pass_cnt++; $display("word after break got=%h", g); end
    endtask

    task automatic test_overrun_reset();
        word_t e, g;
        bit ok;
        logic [7:0] third = 8'h33;
        int ov0 = ovr_cnt[0];
        ready[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, BIT_CLKS);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1, 1'b1, BIT_CLKS);
        @(negedge clk);
        total_cnt++;
        if (dout_w[0] !== 8'h11 || valid_w[0] !== 1'b1)
            $display("FAIL overrun_hold: dout=%h valid=%b required 11/1", dout_w[0], valid_w[0]);
        else begin pass_cnt++; $display("word held dout=%h", dout_w[0]); end
        total_cnt++;
        if (ovr_cnt[0] - ov0 != 1) $display("FAIL overrun_pulse: pulses=%0d required 1", ovr_cnt[0] - ov0);
        else pass_cnt++;
        @(posedge clk); #1;
        drive(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive(0, third[i], BIT_CLKS);
        rst_n = 1'b0;
        rx_l[0] = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({dout_w[0], valid_w[0], pe_w[0], fe_w[0], bk_w[0], ov_w[0]} !== 13'd0)
            $display("FAIL midframe_reset: outputs=%h required 0",
                     {dout_w[0], valid_w[0], pe_w[0], fe_w[0], bk_w[0], ov_w[0]});
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1'b1, 12 * BIT_CLKS);
        total_cnt++;
        if (valid_w[0] !== 1'b0) $display("FAIL reset_discard: valid=%b required 0", valid_w[0]);
        else pass_cnt++;
        ready[0] = 1'b1;
        got_q.delete();
        exp_q.push_back(word_t'{8'h5A, 1'b0, 1'b0, 1'b0});
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 1'b1, BIT_CLKS);
        get_word(g, ok);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || g !== e) $display("FAIL post_reset: got=%h ok=%0d required=%h", g, ok, e);
        else begin pass_cnt++; $display("word after reset got=%h", g); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx_l[i]  = 1'b1;
            ready[i] = 1'b1;
        end
        test_reset();
        test_basic_8n1();
        test_parity();
        test_glitch();
        test_two_stop();
        test_break();
        test_overrun_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
